// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the VGA frame streamer.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [0:0] {
        StIdle,
        StPend
    } cfg_state_e;

    // Upscale code to shift amount; the reserved code 3 behaves like 4x.
    function automatic logic [1:0] scale_shift(input logic [1:0] cfg_scale);
        return (cfg_scale == 2'd3) ? 2'd2 : cfg_scale;
    endfunction

endpackage

// File: rtl/vga_cfg_shadow.sv
// Config handshake: captures a new base/scale into a shadow copy and promotes it
// to the active copy only on a vsync assertion edge, so a frame never tears.
module vga_cfg_shadow
    import vga_pkg::*;
#(
    parameter bit SYNC_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        vsync_in,
    input  logic        cfg_valid,
    input  logic [31:0] cfg_base,
    input  logic [1:0]  cfg_scale,
    output logic        cfg_ready,
    output logic [31:0] act_base,
    output logic [1:0]  act_shift,
    output logic        frame_start
);

    cfg_state_e  state_q, state_d;
    logic [31:0] shadow_base_q, act_base_q;
    logic [1:0]  shadow_shift_q, act_shift_q;
    logic        vs_act, vs_prev_q, vs_edge, frame_start_q;

    // vs_prev_q holds the active-level view of vsync, so 0 means inactive.
    assign vs_act  = SYNC_ACT_LOW ? ~vsync_in : vsync_in;
    assign vs_edge = pix_ce & vs_act & ~vs_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_valid) state_d = StPend;
            StPend:  if (vs_edge) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_prev_q      <= 1'b0;
            frame_start_q  <= 1'b0;
            shadow_base_q  <= '0;
            shadow_shift_q <= '0;
            act_base_q     <= '0;
            act_shift_q    <= '0;
        end else begin
            frame_start_q <= vs_edge;
            if (pix_ce) begin
                vs_prev_q <= vs_act;
            end
            if (state_q == StIdle && cfg_valid) begin
                shadow_base_q  <= cfg_base;
                shadow_shift_q <= scale_shift(cfg_scale);
            end
            if (state_q == StPend && vs_edge) begin
                act_base_q  <= shadow_base_q;
                act_shift_q <= shadow_shift_q;
            end
        end
    end

    assign act_base    = act_base_q;
    assign act_shift   = act_shift_q;
    assign frame_start = frame_start_q;

endmodule

// File: rtl/vga_frame_streamer.sv
// Framebuffer-to-VGA streamer: two-stage pixel pipeline (address, then data)
// with syncs delayed alongside so they stay aligned with the RGB output.
module vga_frame_streamer
    import vga_pkg::*;
#(
    parameter int unsigned IMG_W        = 100,
    parameter int unsigned IMG_H        = 100,
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 0,
    parameter int unsigned BPP          = 3,
    parameter int unsigned ELEM_W       = 32,
    parameter logic [23:0] BG_RGB       = 24'h000000,
    parameter bit          SYNC_ACT_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_ce,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  cfg_valid,
    input  logic [31:0]           cfg_base,
    input  logic [1:0]            cfg_scale,
    output logic                  cfg_ready,
    output logic [31:0]           mem_addr,
    input  logic [3*ELEM_W-1:0]   mem_rdata,
    output logic                  hsync,
    output logic                  vsync,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic                  frame_start
);

    localparam logic [31:0] ROW_STRIDE = 32'(IMG_W * BPP);
    localparam logic [31:0] PIX_STRIDE = 32'(BPP);
    localparam logic        SYNC_IDLE  = SYNC_ACT_LOW;

    logic [31:0] act_base;
    logic [1:0]  act_shift;

    vga_cfg_shadow #(
        .SYNC_ACT_LOW(SYNC_ACT_LOW)
    ) u_cfg (
        .clk        (clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .vsync_in   (vsync_in),
        .cfg_valid  (cfg_valid),
        .cfg_base   (cfg_base),
        .cfg_scale  (cfg_scale),
        .cfg_ready  (cfg_ready),
        .act_base   (act_base),
        .act_shift  (act_shift),
        .frame_start(frame_start)
    );

    logic [31:0] x_pos, y_pos, win_w, win_h, x_off, y_off, addr_d;
    logic [32:0] x_diff, y_diff;
    logic        in_win;

    assign x_pos = 32'(x);
    assign y_pos = 32'(y);
    assign win_w = 32'(IMG_W) << act_shift;
    assign win_h = 32'(IMG_H) << act_shift;

    // 33-bit differences: bit 32 set means the pixel lies above/left of the origin.
    assign x_diff = {1'b0, x_pos} - {1'b0, 32'(X0)};
    assign y_diff = {1'b0, y_pos} - {1'b0, 32'(Y0)};

    assign in_win = video_on && !x_diff[32] && !y_diff[32]
                    && (x_diff[31:0] < win_w) && (y_diff[31:0] < win_h)
                    && (x_pos < H_ACTIVE) && (y_pos < V_ACTIVE);

    assign x_off  = x_diff[31:0] >> act_shift;
    assign y_off  = y_diff[31:0] >> act_shift;
    assign addr_d = act_base + y_off * ROW_STRIDE + x_off * PIX_STRIDE;

    logic [31:0] mem_addr_q;
    logic        s1_video_q, s1_win_q, s1_hs_q, s1_vs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
            s1_video_q <= 1'b0;
            s1_win_q   <= 1'b0;
            s1_hs_q    <= SYNC_IDLE;
            s1_vs_q    <= SYNC_IDLE;
        end else if (pix_ce) begin
            if (in_win) begin
                mem_addr_q <= addr_d;
            end
            s1_video_q <= video_on;
            s1_win_q   <= in_win;
            s1_hs_q    <= hsync_in;
            s1_vs_q    <= vsync_in;
        end
    end

    rgb_t rgb_d, rgb_q;
    logic hs_q, vs_q;

    always_comb begin
        rgb_d = '0;
        if (s1_video_q && !s1_win_q) begin
            rgb_d = rgb_t'(BG_RGB);
        end else if (s1_video_q) begin
            rgb_d.r = mem_rdata[7:0];
            rgb_d.g = mem_rdata[ELEM_W +: 8];
            rgb_d.b = mem_rdata[2*ELEM_W +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q <= '0;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
        end else if (pix_ce) begin
            rgb_q <= rgb_d;
            hs_q  <= s1_hs_q;
            vs_q  <= s1_vs_q;
        end
    end

    // Only the low byte of each element carries a colour channel.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;

    assign mem_addr = mem_addr_q;
    assign r        = rgb_q.r;
    assign g        = rgb_q.g;
    assign b        = rgb_q.b;
    assign hsync    = hs_q;
    assign vsync    = vs_q;

endmodule

// File: doc/vga_frame_streamer.md
Name: vga_frame_streamer

Overview:
- Parametrised framebuffer-to-VGA pixel streamer.
- Sits between HV_sync (supplies x/y/sync/video_on plus a pixel-rate enable) and the vector data memory (combinational 3-element read, dmem_rom style). Drives the DAC RGB and delayed syncs.
- Generalises the fixed 100x100 test pattern:
  - parametric image size and on-screen origin;
  - runtime framebuffer base and integer upscaling (1x/2x/4x);
  - background colour;
  - sync/data pipeline alignment;
  - config handshake that applies only at frame boundaries (no tearing).

Parameters:
- IMG_W, 100, source image width in pixels
- IMG_H, 100, source image height in pixels
- X0, 0, screen x of image top-left
- Y0, 0, screen y of image top-left
- BPP, 3, memory elements per pixel (address stride)
- ELEM_W, 32, bits per memory element; channel = low 8 bits of element
- BG_RGB, 24'h000000, colour inside the active area but outside the image window
- SYNC_ACT_LOW, 1, sync polarity of hsync_in/vsync_in and outputs

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- pix_ce  in  1  pixel-rate enable (25 MHz tick); all pipeline state advances only when high
- x  in  10  current column from HV_sync
- y  in  10  current row from HV_sync
- video_on  in  1  active-area flag
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- cfg_valid  in  1  new config offered
- cfg_base  in  32  framebuffer base address
- cfg_scale  in  2  0=1x, 1=2x, 2=4x, 3 treated as 2
- cfg_ready  out  1  config accepted on cfg_valid&&cfg_ready
- mem_addr  out  32  read address to data memory
- mem_rdata  in  3*ELEM_W  combinational read data for mem_addr
- hsync  out  1  hsync aligned to RGB
- vsync  out  1  vsync aligned to RGB
- r  out  8  red
- g  out  8  green
- b  out  8  blue
- frame_start  out  1  one-clk pulse when the new frame boundary is detected

Behaviour:
- All registers update only on posedge clk. Pipeline registers additionally require pix_ce. Reset overrides pix_ce.
- Reset values:
  - r/g/b = 0; mem_addr = 0.
  - hsync/vsync = inactive level (1 if SYNC_ACT_LOW).
  - Active base = 0, active scale = 0.
  - cfg_ready = 1; frame_start = 0.
  - Pipeline valid bits = 0.
- Window:
  - W = IMG_W << s, H = IMG_H << s, where s = active scale.
  - in_win = video_on && x >= X0 && x < X0+W && y >= Y0 && y < Y0+H.
- Address, stage 1 (registered on pix_ce):
  - mem_addr = base + ((y-Y0)>>s)*IMG_W*BPP + ((x-X0)>>s)*BPP.
  - Arithmetic is 32-bit unsigned.
  - When !in_win, mem_addr holds its previous value (no address toggling).
- Data, stage 2 (registered on pix_ce):
  - r = rdata[7:0], g = rdata[ELEM_W+7:ELEM_W], b = rdata[2*ELEM_W+7:2*ELEM_W].
  - If the stage-1 flags say video_on && !in_win: rgb = BG_RGB.
  - If !video_on: rgb = 0.
- Latency: exactly 2 pix_ce ticks from x/y to RGB. hsync, vsync and video_on are delayed by the same 2 ticks so they stay aligned.
- Config FSM:
  - IDLE: cfg_ready = 1. On cfg_valid, capture cfg_base/cfg_scale into shadow registers and go to PEND.
  - PEND: cfg_ready = 0. Wait for a vsync_in assertion edge, sampled on pix_ce (inactive->active).
  - At that edge: copy shadow to active registers, pulse frame_start for one clk, return to IDLE.
  - frame_start also pulses at every vsync assertion edge in IDLE. The active config is unchanged in that case.
  - The active config never changes mid-frame.
- Boundaries:
  - cfg_valid coinciding with a vsync edge while in IDLE: the captured config is applied at the next frame, not this one.
  - Window clipped by the screen (X0+W > 640): pixels past x=639 are never seen; no wrap.
  - Reset while in PEND: the shadow config is discarded.
  - pix_ce low: every output holds.

Decomposition:
- Package vga_pkg:
  - H_ACTIVE=640, V_ACTIVE=480;
  - rgb_t struct {r,g,b};
  - typedef cfg_state_e {IDLE, PEND};
  - function scale_shift(cfg_scale), which maps 3 to 2.
- One sub-module, vga_cfg_shadow: the config FSM plus shadow and active registers plus vsync edge detection. The top module holds the address and data pipeline.

Test Plan:
- Reset, then idle frame with default config: at screen (0,0) mem_addr=0; at (5,2) mem_addr=2*300+15=615. RGB appears 2 pix_ce ticks later and equals the memory model bytes.
- Pixel outside the window: (150,10) with video_on=1 gives rgb=BG_RGB; during blanking (video_on=0) rgb=0; mem_addr holds its last value.
- Upscaling: cfg_scale=1, cfg_base=0x1000 applied at the vsync edge. Then (3,3) gives mem_addr=0x1000+1*300+1*3; the window extends to x=199, and x=200 gives BG.
- Frame-boundary handshake: cfg_valid asserted mid-frame gives cfg_ready=0 the next clk. The old base stays in use until the vsync edge; frame_start pulses exactly 1 clk; cfg_ready returns to 1.
- Sync alignment: an hsync_in edge appears on hsync exactly 2 pix_ce ticks later, in the same tick as the corresponding RGB change. With pix_ce gated every 2nd clk, outputs hold between ticks.
- Reset asserted while in PEND: cfg_ready=1 the next clk. Active base=0 persists across the following vsync edge.
